ltc2324_axis_packer: RTL

Consumes the four-channel sample strobe (`valid`, `ch1`..`ch4`) of the LTC2324-16 ADC driver and turns it into a 32-bit AXI4-Stream for the DMA write channel. Each sample becomes two beats: `{ch2,ch1}` then `{ch4,ch3}`. A sample FIFO absorbs DMA backpressure, and every `PKT_SAMPLES` samples form one TLAST-terminated packet. Drops are counted, not silently lost.

---
 rtl/ltc2324_pkg.sv | 33 +++
 rtl/ltc2324_sample_fifo.sv | 58 +++++
 rtl/ltc2324_axis_packer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ltc2324_pkg.sv
// ltc2324_pkg: shared widths, FSM encodings and FIFO entry layout for the LTC2324 AXIS packer.
// Rev 1.0
`default_nettype none

package ltc2324_pkg;
  localparam int SAMPLE_W = 16;
  localparam int NUM_CH   = 4;
  localparam int AXIS_W   = 32;
  localparam int ENTRY_W  = NUM_CH * SAMPLE_W + 1;

  typedef enum logic [1:0] {
    IN_IDLE   = 2'd0,
    IN_RUN    = 2'd1,
    IN_FINISH = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_LO   = 2'd1,
    OUT_HI   = 2'd2
  } out_state_t;

  // MSB (bit 64) carries the end-of-packet marker.
  typedef struct packed {
    logic                last;
    logic [SAMPLE_W-1:0] ch4;
    logic [SAMPLE_W-1:0] ch3;
    logic [SAMPLE_W-1:0] ch2;
    logic [SAMPLE_W-1:0] ch1;
  } fifo_entry_t;
endpackage

`default_nettype wire

// File: rtl/ltc2324_sample_fifo.sv
// ltc2324_sample_fifo: synchronous FIFO with registered read data and occupancy count.
// Rev 1.0
`default_nettype none

module ltc2324_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/ltc2324_axis_packer.sv
// ltc2324_axis_packer: packs 4x16-bit ADC samples into a 2-beat-per-sample, packetised AXI4-Stream.
// Rev 1.0
`default_nettype none

module ltc2324_axis_packer
  import ltc2324_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int PKT_SAMPLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] ch1,
  input  logic [SAMPLE_W-1:0] ch2,
  input  logic [SAMPLE_W-1:0] ch3,
  input  logic [SAMPLE_W-1:0] ch4,
  output logic [AXIS_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [3:0]          m_axis_tkeep,
  output logic                overflow,
  output logic [15:0]         drop_cnt,
  output logic                busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  in_state_t   in_state, in_nxt;
  out_state_t  out_state, out_nxt;
  logic [15:0] in_cnt, cnt_nxt;
  logic        pend_last;
  logic        capture, is_last, push, drop, pop, release_slot, slots_full, holding;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  fifo_entry_t wr_entry, rd_entry;

  assign capture      = valid && (in_state != IN_IDLE);
  assign is_last      = (in_cnt == 16'(PKT_SAMPLES - 1));
  assign holding      = (out_state != OUT_IDLE);
  assign release_slot = (out_state == OUT_HI) && m_axis_tready;
  // The sample parked in the output register counts against FIFO_DEPTH.
  assign slots_full   = fifo_full || (holding && fifo_count == (AW+1)'(FIFO_DEPTH - 1));
  assign push         = capture && (!slots_full || release_slot);
  assign drop         = capture && !push;
  assign wr_entry     = '{last: is_last | pend_last, ch4: ch4, ch3: ch3, ch2: ch2, ch1: ch1};

  ltc2324_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    cnt_nxt = in_cnt;
    if (capture) cnt_nxt = is_last ? 16'd0 : in_cnt + 16'd1;
    in_nxt = in_state;
    case (in_state)
      IN_IDLE:   if (enable) in_nxt = IN_RUN;
      // Looks at the post-capture count so a strobe in this cycle cannot strand a partial packet.
      IN_RUN:    if (!enable) in_nxt = (cnt_nxt != 16'd0) ? IN_FINISH : IN_IDLE;
      IN_FINISH: if (capture && is_last) in_nxt = IN_IDLE;
      default:   in_nxt = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state  <= IN_IDLE;
      in_cnt    <= 16'd0;
      pend_last <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= 16'd0;
    end else begin
      in_state <= in_nxt;
      in_cnt   <= cnt_nxt;
      if (push)                 pend_last <= 1'b0;
      else if (drop && is_last) pend_last <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    pop     = 1'b0;
    out_nxt = out_state;
    case (out_state)
      OUT_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        out_nxt = OUT_LO;
      end
      OUT_LO:   if (m_axis_tready) out_nxt = OUT_HI;
      OUT_HI:   if (m_axis_tready) begin
        pop     = !fifo_empty;
        out_nxt = fifo_empty ? OUT_IDLE : OUT_LO;
      end
      default:  out_nxt = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_state <= OUT_IDLE;
    else        out_state <= out_nxt;
  end

  always_comb begin
    m_axis_tdata = '0;
    case (out_state)
      OUT_LO:  m_axis_tdata = {rd_entry.ch2, rd_entry.ch1};
      OUT_HI:  m_axis_tdata = {rd_entry.ch4, rd_entry.ch3};
      default: m_axis_tdata = '0;
    endcase
  end

  assign m_axis_tvalid = holding;
  assign m_axis_tlast  = (out_state == OUT_HI) && rd_entry.last;
  assign m_axis_tkeep  = 4'hF;
  assign busy          = (in_state != IN_IDLE) || !fifo_empty || holding;
endmodule

`default_nettype wire
